// File: rtl/seg7_pkg.sv
// Shared glyph table and per-nibble BCD step helpers for the 7-segment counter display.
package seg7_pkg;

  typedef struct packed {
    logic       carry;
    logic [3:0] nib;
  } nib_step_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  // {A,B,C,D,E,F,G}, A = MSB, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (h)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic nib_step_t bcd_inc(input logic [3:0] n);
    nib_step_t r;
    if (n >= BCD_MAX) begin
      r.carry = 1'b1;
      r.nib   = '0;
    end else begin
      r.carry = 1'b0;
      r.nib   = n + 4'd1;
    end
    return r;
  endfunction

  // Out-of-range nibbles snap to 9 and absorb the borrow.
  function automatic nib_step_t bcd_dec(input logic [3:0] n);
    nib_step_t r;
    if (n == 4'd0) begin
      r.carry = 1'b1;
      r.nib   = BCD_MAX;
    end else if (n > BCD_MAX) begin
      r.carry = 1'b0;
      r.nib   = BCD_MAX;
    end else begin
      r.carry = 1'b0;
      r.nib   = n - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Free-running prescaler producing a 1-cycle tick every 2^DIV clock cycles.
module seg7_tick_gen #(
  parameter int unsigned DIV = 15
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [DIV-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    tick  = &cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg7_counter_display.sv
// N-digit hex/BCD up/down loadable counter with multiplexed, leading-zero-blanked 7-segment output.
module seg7_counter_display
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SCAN_DIV    = 15,
  parameter int unsigned CNT_DIV     = 21,
  parameter bit          AN_ACT_LOW  = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  bcd_mode,
  input  logic                  blank_lz,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap,
  output logic [DIGITS-1:0]     anodes,
  output logic [6:0]            segments
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] AN_OFF  = AN_ACT_LOW ? '1 : '0;
  localparam logic [6:0]        SEG_OFF = SEG_ACT_LOW ? ~SEG_BLANK : SEG_BLANK;

  logic scan_tick, cnt_tick;

  seg7_tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (.clk(clk), .rst(rst), .tick(scan_tick));
  seg7_tick_gen #(.DIV(CNT_DIV))  u_cnt_tick  (.clk(clk), .rst(rst), .tick(cnt_tick));

  logic [W-1:0]        value_q, value_d;
  logic                wrap_q, wrap_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   anodes_q, anodes_d;
  logic [6:0]          segments_q, segments_d;

  logic [W-1:0]        step_val, load_clamped, upper;
  logic [W:0]          sum;
  logic                step_carry, carry;
  nib_step_t           ns;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   onehot;

  always_comb begin
    step_val     = value_q;
    step_carry   = 1'b0;
    carry        = 1'b1;
    sum          = '0;
    ns           = '0;
    load_clamped = load_val;
    if (bcd_mode) begin
      // Ripple the carry/borrow nibble by nibble; nibbles above the stop point are untouched.
      for (int unsigned i = 0; i < DIGITS; i++) begin
        ns = up ? bcd_inc(value_q[4*i +: 4]) : bcd_dec(value_q[4*i +: 4]);
        if (carry) begin
          step_val[4*i +: 4] = ns.nib;
          carry              = ns.carry;
        end
        if (load_val[4*i +: 4] > BCD_MAX) load_clamped[4*i +: 4] = BCD_MAX;
      end
      step_carry = carry;
    end else begin
      sum        = up ? ({1'b0, value_q} + {{W{1'b0}}, 1'b1})
                      : ({1'b0, value_q} - {{W{1'b0}}, 1'b1});
      step_val   = sum[W-1:0];
      step_carry = sum[W];
    end

    value_d = value_q;
    wrap_d  = 1'b0;
    if (load) begin
      value_d = load_clamped;
    end else if (cnt_tick && en) begin
      value_d = step_val;
      wrap_d  = step_carry;
    end
  end

  always_comb begin
    idx_d      = idx_q;
    anodes_d   = anodes_q;
    segments_d = segments_q;
    nib        = '0;
    upper      = '0;
    onehot     = '0;
    if (scan_tick) begin
      idx_d          = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      nib            = value_q[{idx_d, 2'b00} +: 4];
      upper          = value_q >> {idx_d, 2'b00};
      onehot[idx_d]  = 1'b1;
      if (blank_lz && (idx_d != '0) && (upper == '0)) begin
        anodes_d   = AN_OFF;
        segments_d = SEG_OFF;
      end else begin
        anodes_d   = AN_ACT_LOW ? ~onehot : onehot;
        segments_d = SEG_ACT_LOW ? ~hex_to_seg(nib) : hex_to_seg(nib);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q    <= '0;
      wrap_q     <= 1'b0;
      idx_q      <= '0;
      anodes_q   <= AN_OFF;
      segments_q <= SEG_OFF;
    end else begin
      value_q    <= value_d;
      wrap_q     <= wrap_d;
      idx_q      <= idx_d;
      anodes_q   <= anodes_d;
      segments_q <= segments_d;
    end
  end

  assign value    = value_q;
  assign wrap     = wrap_q;
  assign anodes   = anodes_q;
  assign segments = segments_q;

endmodule
